// File: rtl/vfpu_engine.sv
// Elementwise vector integer engine: joins operand streams A and B, applies a
// per-lane 32-bit operation and returns results through a 2-stage elastic pipe.
module vfpu_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int NB_LANES   = DATA_WIDTH / 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [2:0]              op_i,
    input  logic [CNT_WIDTH-1:0]    len_i,
    input  logic [DATA_WIDTH-1:0]   a_data_i,
    input  logic [DATA_WIDTH/8-1:0] a_strb_i,
    input  logic                    a_valid_i,
    output logic                    a_ready_o,
    input  logic [DATA_WIDTH-1:0]   b_data_i,
    input  logic [DATA_WIDTH/8-1:0] b_strb_i,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [DATA_WIDTH/8-1:0] r_strb_o,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_WIDTH-1:0]    beat_cnt_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_q;
    logic [2:0]            op_q;
    logic [CNT_WIDTH-1:0]  len_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [STRB_WIDTH-1:0] s1_strb_q;
    logic                  s2_valid_q;
    logic [DATA_WIDTH-1:0] s2_data_q;
    logic [STRB_WIDTH-1:0] s2_strb_q;

    logic                  s1_can_load;
    logic                  s2_can_load;
    logic                  accept;
    logic                  last_beat;
    logic                  drain_done;
    logic [DATA_WIDTH-1:0] op_result;

    function automatic logic [31:0] lane_op(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] res;
        case (op)
            3'd0:    res = a + b;
            3'd1:    res = a - b;
            3'd2:    res = a * b;
            3'd3:    res = ($signed(a) < $signed(b)) ? a : b;
            3'd4:    res = ($signed(a) > $signed(b)) ? a : b;
            default: res = a;
        endcase
        return res;
    endfunction

    always_comb begin
        op_result = '0;
        for (int l = 0; l < NB_LANES; l++) begin
            op_result[l*32 +: 32] = lane_op(op_q, a_data_i[l*32 +: 32], b_data_i[l*32 +: 32]);
        end
    end

    // Both sides see the same ready, so a beat is never consumed from only one stream.
    assign s2_can_load = !s2_valid_q || r_ready_i;
    assign s1_can_load = !s1_valid_q || s2_can_load;
    assign accept      = (state_q == ST_RUN) && a_valid_i && b_valid_i && s1_can_load;
    assign last_beat   = accept && ((cnt_q + CNT_WIDTH'(1)) == len_q);
    assign drain_done  = (state_q == ST_DRAIN) && !s1_valid_q && !s2_valid_q;

    assign a_ready_o  = accept;
    assign b_ready_o  = accept;
    assign r_data_o   = s2_data_q;
    assign r_strb_o   = s2_strb_q;
    assign r_valid_o  = s2_valid_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = drain_done;
    assign beat_cnt_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_strb_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_strb_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q    <= op_i;
                        len_q   <= len_i;
                        cnt_q   <= '0;
                        state_q <= (len_i == '0) ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_beat) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept && (cnt_q != len_q)) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end

            if (s1_can_load) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q <= op_result;
                    s1_strb_q <= a_strb_i & b_strb_i;
                end
            end

            // Output register only advances when empty or being consumed, keeping r_* stable on stall.
            if (s2_can_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                    s2_strb_q <= s1_strb_q;
                end
            end
        end
    end

endmodule
